// File: rtl/intr_ctrl.sv
// Two-source interrupt controller: edge capture with overrun flags, mask,
// fixed-priority single-level request FSM with a post-return hold-off gap.
module intr_ctrl #(
  parameter int unsigned GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev1,
  input  logic       ev2,
  input  logic       mask_we,
  input  logic [1:0] mask_d,
  input  logic       iret,
  input  logic       clr_ovf,
  output logic       s_intr1,
  output logic       s_intr2,
  output logic [7:0] status
);

  // state   | meaning
  // IDLE    | waiting for an unmasked pending source
  // REQ     | one-cycle vector request to the CPU
  // SERVICE | handler running, no nesting, waiting for iret
  // HOLD    | GAP idle cycles after return before arbitrating again
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam int          GAP_I     = int'(GAP);
  localparam logic [3:0]  HOLD_LOAD = (GAP_I > 0) ? 4'(GAP_I - 1) : 4'd0;

  logic [1:0] state;
  logic [1:0] ev_s;
  logic [1:0] ev_p;
  logic [1:0] pending;
  logic [1:0] mask;
  logic [1:0] isr_id;
  logic [1:0] ovf;
  logic [3:0] hold_cnt;

  logic [1:0] edge_det;
  logic [1:0] pend_clr;
  logic [1:0] req_vec;

  assign edge_det = ev_s & ~ev_p;
  assign pend_clr = (state == ST_REQ) ? isr_id : 2'b00;
  assign req_vec  = pending & ~mask;

  // A fresh edge landing on the clearing edge re-arms pending and is not an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_s    <= 2'b00;
      ev_p    <= 2'b00;
      pending <= 2'b00;
      ovf     <= 2'b00;
      mask    <= 2'b11;
    end else begin
      ev_s    <= {ev2, ev1};
      ev_p    <= ev_s;
      pending <= (pending & ~pend_clr) | edge_det;
      ovf     <= (ovf & ~{2{clr_ovf}}) | (edge_det & pending & ~pend_clr);
      if (mask_we) mask <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      isr_id   <= 2'b00;
      hold_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_vec != 2'b00) begin
            state  <= ST_REQ;
            isr_id <= req_vec[0] ? 2'b01 : 2'b10;
          end
        end
        ST_REQ: state <= ST_SERVICE;
        ST_SERVICE: begin
          if (iret) begin
            isr_id <= 2'b00;
            if (GAP_I > 0) begin
              state    <= ST_HOLD;
              hold_cnt <= HOLD_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt == 4'd0) state <= ST_IDLE;
          else hold_cnt <= hold_cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_intr1 = (state == ST_REQ) && isr_id[0];
  assign s_intr2 = (state == ST_REQ) && isr_id[1];
  assign status  = {2'b00, ovf[1], ovf[0], isr_id, pending};

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a GAP=2 instance and a GAP=0 instance share stimulus.
module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset, ev1, ev2, mask_we, iret, clr_ovf;
  logic [1:0] mask_d;
  logic       a_intr1, a_intr2, z_intr1, z_intr2;
  logic [7:0] a_status, z_status;
  int         n_cmp = 0;
  int         n_err = 0;

  intr_ctrl #(.GAP(2)) u_gap2 (
    .clk(clk), .reset(reset), .ev1(ev1), .ev2(ev2), .mask_we(mask_we),
    .mask_d(mask_d), .iret(iret), .clr_ovf(clr_ovf),
    .s_intr1(a_intr1), .s_intr2(a_intr2), .status(a_status)
  );

  intr_ctrl #(.GAP(0)) u_gap0 (
    .clk(clk), .reset(reset), .ev1(ev1), .ev2(ev2), .mask_we(mask_we),
    .mask_d(mask_d), .iret(iret), .clr_ovf(clr_ovf),
    .s_intr1(z_intr1), .s_intr2(z_intr2), .status(z_status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ev1 = 0; ev2 = 0; mask_we = 0; mask_d = 2'b00; iret = 0; clr_ovf = 0;
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic unmask_all();
    mask_we = 1; mask_d = 2'b00;
    tick();
    mask_we = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (a_status !== 8'h00) begin n_err++; $display("FAIL reset_status got=%h exp=00", a_status); end
    n_cmp++;
    if ({a_intr1, a_intr2} !== 2'b00) begin n_err++; $display("FAIL reset_intr got=%b exp=00", {a_intr1, a_intr2}); end
    // Reset mask is 11: the edge is latched but never requested.
    ev2 = 1;
    repeat (5) tick();
    n_cmp++;
    if (a_status !== 8'h02) begin n_err++; $display("FAIL reset_mask_status got=%h exp=02", a_status); end
    n_cmp++;
    if (a_intr2 !== 1'b0) begin n_err++; $display("FAIL reset_mask_intr2 got=%b exp=0", a_intr2); end
  endtask

  task automatic test_single();
    do_reset();
    unmask_all();
    ev1 = 1;
    tick();
    n_cmp++;
    if (a_status !== 8'h00) begin n_err++; $display("FAIL single_sample got=%h exp=00", a_status); end
    tick();
    n_cmp++;
    if (a_status !== 8'h01) begin n_err++; $display("FAIL single_pending got=%h exp=01", a_status); end
    n_cmp++;
    if (a_intr1 !== 1'b0) begin n_err++; $display("FAIL single_early got=%b exp=0", a_intr1); end
    tick();
    n_cmp++;
    if ({a_intr1, a_intr2} !== 2'b10) begin n_err++; $display("FAIL single_req got=%b exp=10", {a_intr1, a_intr2}); end
    n_cmp++;
    if (a_status !== 8'h05) begin n_err++; $display("FAIL single_req_status got=%h exp=05", a_status); end
    tick();
    n_cmp++;
    if (a_status !== 8'h04) begin n_err++; $display("FAIL single_service got=%h exp=04", a_status); end
    n_cmp++;
    if (a_intr1 !== 1'b0) begin n_err++; $display("FAIL single_pulse_len got=%b exp=0", a_intr1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    unmask_all();
    ev1 = 1; ev2 = 1;
    tick();
    tick();
    n_cmp++;
    if (a_status !== 8'h03) begin n_err++; $display("FAIL b2b_pending got=%h exp=03", a_status); end
    tick();
    n_cmp++;
    if ({a_intr1, a_intr2} !== 2'b10) begin n_err++; $display("FAIL b2b_first got=%b exp=10", {a_intr1, a_intr2}); end
    tick();
    n_cmp++;
    if (a_status !== 8'h06) begin n_err++; $display("FAIL b2b_service1 got=%h exp=06", a_status); end
    iret = 1;
    tick();
    iret = 0;
    n_cmp++;
    if (a_status !== 8'h02) begin n_err++; $display("FAIL b2b_hold got=%h exp=02", a_status); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({a_intr1, a_intr2} !== 2'b00) begin n_err++; $display("FAIL b2b_gap%0d got=%b exp=00", i, {a_intr1, a_intr2}); end
      tick();
    end
    n_cmp++;
    if ({a_intr1, a_intr2} !== 2'b00) begin n_err++; $display("FAIL b2b_idle got=%b exp=00", {a_intr1, a_intr2}); end
    tick();
    n_cmp++;
    if ({a_intr1, a_intr2} !== 2'b01) begin n_err++; $display("FAIL b2b_second got=%b exp=01", {a_intr1, a_intr2}); end
    n_cmp++;
    if (a_status !== 8'h0A) begin n_err++; $display("FAIL b2b_req2_status got=%h exp=0A", a_status); end
    tick();
    n_cmp++;
    if (a_status !== 8'h08) begin n_err++; $display("FAIL b2b_service2 got=%h exp=08", a_status); end
  endtask

  task automatic test_mask();
    do_reset();
    mask_we = 1; mask_d = 2'b01;
    tick();
    mask_we = 0;
    ev1 = 1;
    repeat (5) tick();
    n_cmp++;
    if (a_status !== 8'h01) begin n_err++; $display("FAIL mask_hold got=%h exp=01", a_status); end
    n_cmp++;
    if (a_intr1 !== 1'b0) begin n_err++; $display("FAIL mask_block got=%b exp=0", a_intr1); end
    mask_we = 1; mask_d = 2'b00;
    tick();
    mask_we = 0;
    n_cmp++;
    if (a_intr1 !== 1'b0) begin n_err++; $display("FAIL mask_load got=%b exp=0", a_intr1); end
    tick();
    n_cmp++;
    if (a_intr1 !== 1'b1) begin n_err++; $display("FAIL mask_release got=%b exp=1", a_intr1); end
    // Remasking during REQ must not cancel the request in flight.
    mask_we = 1; mask_d = 2'b11;
    tick();
    mask_we = 0;
    n_cmp++;
    if (a_status !== 8'h04) begin n_err++; $display("FAIL mask_late got=%h exp=04", a_status); end
  endtask

  task automatic test_overrun();
    do_reset();
    unmask_all();
    ev2 = 1;
    repeat (4) tick();
    n_cmp++;
    if (a_status !== 8'h08) begin n_err++; $display("FAIL ovf_service got=%h exp=08", a_status); end
    ev2 = 0; tick(); ev2 = 1; tick(); tick();
    n_cmp++;
    if (a_status !== 8'h0A) begin n_err++; $display("FAIL ovf_first got=%h exp=0A", a_status); end
    ev2 = 0; tick(); ev2 = 1; tick(); tick();
    n_cmp++;
    if (a_status !== 8'h2A) begin n_err++; $display("FAIL ovf_set got=%h exp=2A", a_status); end
    clr_ovf = 1; tick(); clr_ovf = 0;
    n_cmp++;
    if (a_status !== 8'h0A) begin n_err++; $display("FAIL ovf_clear got=%h exp=0A", a_status); end
    ev2 = 0; tick(); ev2 = 1; tick();
    clr_ovf = 1; tick(); clr_ovf = 0;
    n_cmp++;
    if (a_status !== 8'h2A) begin n_err++; $display("FAIL ovf_wins got=%h exp=2A", a_status); end
  endtask

  task automatic test_req_clear_edge();
    do_reset();
    unmask_all();
    ev1 = 1; tick();
    ev1 = 0; tick();
    ev1 = 1; tick();
    n_cmp++;
    if (a_intr1 !== 1'b1) begin n_err++; $display("FAIL rce_req got=%b exp=1", a_intr1); end
    tick();
    n_cmp++;
    if (a_status !== 8'h05) begin n_err++; $display("FAIL rce_keep got=%h exp=05", a_status); end
  endtask

  task automatic test_iret_reset();
    do_reset();
    unmask_all();
    iret = 1; tick(); iret = 0;
    n_cmp++;
    if (a_status !== 8'h00) begin n_err++; $display("FAIL iret_idle got=%h exp=00", a_status); end
    ev1 = 1;
    repeat (3) tick();
    n_cmp++;
    if (a_intr1 !== 1'b1) begin n_err++; $display("FAIL iret_then_req got=%b exp=1", a_intr1); end
    reset = 1;
    tick();
    reset = 0; ev1 = 0;
    n_cmp++;
    if ({a_intr1, a_intr2} !== 2'b00) begin n_err++; $display("FAIL rst_mid_intr got=%b exp=00", {a_intr1, a_intr2}); end
    n_cmp++;
    if (a_status !== 8'h00) begin n_err++; $display("FAIL rst_mid_status got=%h exp=00", a_status); end
  endtask

  task automatic test_gap0();
    do_reset();
    unmask_all();
    ev1 = 1; ev2 = 1;
    repeat (3) tick();
    n_cmp++;
    if ({z_intr1, z_intr2} !== 2'b10) begin n_err++; $display("FAIL gap0_first got=%b exp=10", {z_intr1, z_intr2}); end
    tick();
    iret = 1; tick(); iret = 0;
    n_cmp++;
    if (z_status !== 8'h02) begin n_err++; $display("FAIL gap0_idle got=%h exp=02", z_status); end
    tick();
    n_cmp++;
    if ({z_intr1, z_intr2} !== 2'b01) begin n_err++; $display("FAIL gap0_second got=%b exp=01", {z_intr1, z_intr2}); end
    n_cmp++;
    if (z_status !== 8'h0A) begin n_err++; $display("FAIL gap0_status got=%h exp=0A", z_status); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mask();
    test_overrun();
    test_req_clear_edge();
    test_iret_reset();
    test_gap0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter: GAP, default 2, number of idle cycles enforced after a return from interrupt before the next request; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ev1  input  1  external event source 1 (timer tick), level, synchronous to clk.
REQ-005 ev2  input  1  external event source 2 (button/peripheral), level, synchronous to clk.
REQ-006 mask_we  input  1  load enable for the mask register.
REQ-007 mask_d  input  2  new mask value; bit k-1 = 1 masks source k.
REQ-008 iret  input  1  one-cycle pulse from the CPU marking return from the interrupt routine.
REQ-009 clr_ovf  input  1  one-cycle pulse clearing the overrun flags.
REQ-010 s_intr1  output  1  one-cycle request to the CPU to vector to the source-1 handler.
REQ-011 s_intr2  output  1  one-cycle request to the CPU to vector to the source-2 handler.
REQ-012 status  output  8  {2'b00, ovf2, ovf1, isr_id[1:0], pending[1:0]}, readable through a CPU input port.

Function
REQ-013 The block SHALL register ev1/ev2 each cycle and detect rising edges: an edge exists when the sample is 1 and the previous sample is 0.
REQ-014 A rising edge on source k SHALL set pending[k-1] at the same clock edge at which it is detected, visible the following cycle.
REQ-015 An edge on source k while pending[k-1] is already 1 SHALL set sticky ovfk; the event is not counted twice.
REQ-016 clr_ovf SHALL clear ovf1 and ovf2; a simultaneous overrun on source k SHALL win, leaving ovfk = 1.
REQ-017 The mask register SHALL load mask_d on mask_we; masking SHALL NOT block latching of pending, only issuing of requests.
REQ-018 The FSM SHALL have the states IDLE, REQ, SERVICE and HOLD.
REQ-019 IDLE -> REQ when (pending & ~mask) != 0; source 1 has fixed priority over source 2; the selected id is latched into isr_id (01 = src1, 10 = src2).
REQ-020 In REQ, exactly one of s_intr1/s_intr2 SHALL be 1, matching isr_id, for exactly one cycle (Moore output); REQ -> SERVICE unconditionally.
REQ-021 The pending bit of the selected source SHALL clear at the REQ -> SERVICE edge, unless a new edge on that source occurs in the same cycle, in which case it SHALL remain 1 with no overrun flagged.
REQ-022 In SERVICE, no new request SHALL be issued (no nesting); iret -> HOLD when GAP > 0, or -> IDLE when GAP = 0; isr_id clears to 00 on leaving SERVICE.
REQ-023 In HOLD, a 4-bit down-counter loaded with GAP-1 on entry SHALL count to 0, then HOLD -> IDLE; the number of cycles in HOLD is exactly GAP.
REQ-024 iret outside SERVICE SHALL be ignored.
REQ-025 Latency: an edge detected at edge n, with the block IDLE and unmasked, SHALL produce the request pulse in the cycle following edge n+2.
REQ-026 A mask change during REQ or SERVICE SHALL NOT cancel the request already issued.

Reset
REQ-027 reset SHALL force: state IDLE, pending = 00, ovf1 = ovf2 = 0, isr_id = 00, mask = 2'b11 (all masked), edge samples = 0, HOLD counter = 0, s_intr1 = s_intr2 = 0, status = 8'h00.
REQ-028 reset asserted mid-operation (any state) SHALL take priority over all other inputs and drop any pulse in flight the next cycle.

Verification
REQ-029 Reset, mask = 00, ev1 rises -> status = 8'h01 one cycle later, s_intr1 pulse for one cycle two edges after detection, status = 8'h04 in SERVICE.
REQ-030 ev1 and ev2 rise in the same cycle -> s_intr1 first; after iret plus GAP = 2 cycles, s_intr2 pulse; status pending bits clear in order.
REQ-031 mask = 01, ev1 rises -> no pulse, pending = 01 held; write mask = 00 -> s_intr1 issued on the following cycles.
REQ-032 In SERVICE, ev2 rises twice -> ovf2 = 1 (status bit 5); clr_ovf -> status bit 5 = 0; a simultaneous overrun and clr_ovf leave the bit set.
REQ-033 iret pulsed in IDLE -> no state change; reset asserted during REQ -> s_intr lines 0 the next cycle and status = 8'h00.
REQ-034 GAP = 0 build: iret with a pending unmasked source -> IDLE, then REQ in consecutive cycles, with no HOLD cycle.
